// File: rtl/mmu_pkg.sv
// Shared MMU geometry, TLB<->PTW channel types and TLB helper functions.
// Level L leaf covers the top (L+1)*PAGE_LVL_BITS vpn bits; level LEVELS-1 is a base page.
package mmu_pkg;
  localparam int LEVELS        = 3;
  localparam int PAGE_LVL_BITS = 9;
  localparam int VPN_SIZE      = LEVELS * PAGE_LVL_BITS;
  localparam int PPN_SIZE      = 44;
  localparam int LVL_W         = 2;

  typedef struct packed {
    logic [PPN_SIZE-1:0] ppn;
    logic [1:0]          rsw;
    logic d, a, g, u, x, w, r, v;
  } pte_t;

  typedef struct packed {
    logic                valid;
    logic [VPN_SIZE-1:0] vpn;
    logic [1:0]          prv;
    logic                store;
    logic                fetch;
  } tlb_ptw_req_t;

  typedef struct packed {
    tlb_ptw_req_t req;
  } tlb_ptw_comm_t;

  typedef struct packed {
    logic             valid;
    logic             error;
    logic [LVL_W-1:0] level;
    pte_t             pte;
  } ptw_tlb_resp_t;

  typedef struct packed {
    logic sum;
  } ptw_status_t;

  typedef struct packed {
    ptw_tlb_resp_t resp;
    logic          ptw_ready;
    ptw_status_t   ptw_status;
    logic          invalidate_tlb;
  } ptw_tlb_comm_t;

  typedef struct packed {
    logic                valid;
    logic [VPN_SIZE-1:0] vpn;
    logic [LVL_W-1:0]    level;
    pte_t                pte;
  } tlb_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_PTW_REQ, S_PTW_WAIT} tlb_state_t;

  // Low vpn bits that a leaf at this level passes straight through to the ppn.
  function automatic logic [VPN_SIZE-1:0] low_mask(logic [LVL_W-1:0] level);
    logic [VPN_SIZE-1:0] m;
    m = '0;
    for (int c = 0; c < LEVELS; c++)
      if (c + int'(level) < LEVELS - 1) m[c*PAGE_LVL_BITS +: PAGE_LVL_BITS] = '1;
    return m;
  endfunction

  function automatic logic [PPN_SIZE-1:0] form_ppn(logic [PPN_SIZE-1:0] ppn,
                                                   logic [VPN_SIZE-1:0] vpn,
                                                   logic [LVL_W-1:0] level);
    logic [PPN_SIZE-1:0] mask;
    mask = {{(PPN_SIZE-VPN_SIZE){1'b0}}, low_mask(level)};
    return (ppn & ~mask) | ({{(PPN_SIZE-VPN_SIZE){1'b0}}, vpn} & mask);
  endfunction

  function automatic logic perm_ok(pte_t pte, logic [1:0] prv, logic sum,
                                   logic store, logic fetch);
    logic eff_u, access_ok;
    eff_u = (prv == 2'd0) || ((prv == 2'd1) && sum);
    if (fetch)      access_ok = pte.x;
    else if (store) access_ok = pte.w && pte.r;
    else            access_ok = pte.r;
    return access_ok && (pte.u == eff_u);
  endfunction
endpackage

// File: rtl/pseudoLRU.sv
// Tree pseudo-LRU replacement for a power-of-two set of entries.
module pseudoLRU #(
  parameter int ENTRIES = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       touch_i,
  input  logic [$clog2(ENTRIES)-1:0] touch_idx_i,
  output logic [$clog2(ENTRIES)-1:0] victim_o
);
  localparam int IDX_W = $clog2(ENTRIES);

  // Heap-ordered node bits, root at index 1; a set bit steers the victim search right.
  logic [ENTRIES-1:0] tree_q, tree_d;
  logic               unused_slot;
  assign unused_slot = tree_q[0];

  always_comb begin
    logic [IDX_W-1:0] node;
    tree_d = tree_q;
    node   = IDX_W'(1);
    for (int d = 0; d < IDX_W; d++) begin
      tree_d[node] = ~touch_idx_i[IDX_W-1-d];
      node = (node << 1) | IDX_W'(touch_idx_i[IDX_W-1-d]);
    end
  end

  always_comb begin
    logic [IDX_W-1:0] node;
    victim_o = '0;
    node     = IDX_W'(1);
    for (int d = 0; d < IDX_W; d++) begin
      victim_o[IDX_W-1-d] = tree_q[node];
      node = (node << 1) | IDX_W'(tree_q[node]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        tree_q <= '0;
    else if (touch_i) tree_q <= tree_d;
  end
endmodule

// File: rtl/mmu_tlb.sv
// Fully-associative TLB in front of the page-table walker; refills on miss,
// checks permissions, and invalidates entries whose A/D bits need a fresh walk.
module mmu_tlb
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                core_req_valid_i,
  output logic                core_req_ready_o,
  input  logic [VPN_SIZE-1:0] core_req_vpn_i,
  input  logic [1:0]          core_req_prv_i,
  input  logic                core_req_store_i,
  input  logic                core_req_fetch_i,
  output logic                core_resp_valid_o,
  output logic [PPN_SIZE-1:0] core_resp_ppn_o,
  output logic                core_resp_fault_o,
  input  logic                flush_i,
  output tlb_ptw_comm_t       tlb_ptw_comm_o,
  input  ptw_tlb_comm_t       ptw_tlb_comm_i,
  output logic                pmu_tlb_hit_o,
  output logic                pmu_tlb_miss_o
);
  localparam int IDX_W = $clog2(ENTRIES);

  tlb_state_t                 state_q;
  tlb_entry_t [ENTRIES-1:0]   entry_q;
  logic [VPN_SIZE-1:0]        vpn_q;
  logic [1:0]                 prv_q;
  logic                       store_q, fetch_q, req_valid_q;
  logic                       resp_valid_q, resp_fault_q, pmu_hit_q, pmu_miss_q;
  logic [PPN_SIZE-1:0]        resp_ppn_q;

  logic                       hit, free_found, flush_any, sum;
  logic [IDX_W-1:0]           hit_idx, free_idx, victim_idx, refill_idx;
  tlb_entry_t                 hit_entry;
  logic                       hit_perm, hit_ad_ok, refill_perm, plru_touch;
  logic [IDX_W-1:0]           plru_idx;
  ptw_tlb_resp_t              resp;
  logic                       unused_entry_bits;

  assign resp      = ptw_tlb_comm_i.resp;
  assign sum       = ptw_tlb_comm_i.ptw_status.sum;
  assign flush_any = flush_i || ptw_tlb_comm_i.invalidate_tlb;

  // Descending scans so the lowest matching / free index wins.
  always_comb begin
    hit = 1'b0; hit_idx = '0; free_found = 1'b0; free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (entry_q[i].valid &&
          (((entry_q[i].vpn ^ vpn_q) & ~low_mask(entry_q[i].level)) == '0)) begin
        hit = 1'b1; hit_idx = IDX_W'(i);
      end
      if (!entry_q[i].valid) begin
        free_found = 1'b1; free_idx = IDX_W'(i);
      end
    end
  end

  assign hit_entry   = entry_q[hit_idx];
  assign hit_perm    = perm_ok(hit_entry.pte, prv_q, sum, store_q, fetch_q);
  assign hit_ad_ok   = hit_entry.pte.a && (!store_q || hit_entry.pte.d);
  assign refill_idx  = free_found ? free_idx : victim_idx;
  assign refill_perm = perm_ok(resp.pte, prv_q, sum, store_q, fetch_q);

  assign plru_touch = ((state_q == S_LOOKUP) && hit && (!hit_perm || hit_ad_ok)) ||
                      ((state_q == S_PTW_WAIT) && resp.valid && !resp.error && !flush_any);
  assign plru_idx   = (state_q == S_LOOKUP) ? hit_idx : refill_idx;

  pseudoLRU #(.ENTRIES(ENTRIES)) u_plru (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .touch_i    (plru_touch),
    .touch_idx_i(plru_idx),
    .victim_o   (victim_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      entry_q      <= '0;
      vpn_q        <= '0;
      prv_q        <= '0;
      store_q      <= 1'b0;
      fetch_q      <= 1'b0;
      req_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_ppn_q   <= '0;
      pmu_hit_q    <= 1'b0;
      pmu_miss_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      pmu_hit_q    <= 1'b0;
      pmu_miss_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (core_req_valid_i) begin
            vpn_q   <= core_req_vpn_i;
            prv_q   <= core_req_prv_i;
            store_q <= core_req_store_i;
            fetch_q <= core_req_fetch_i;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit && (!hit_perm || hit_ad_ok)) begin
            resp_valid_q <= 1'b1;
            resp_fault_q <= !hit_perm;
            resp_ppn_q   <= form_ppn(hit_entry.pte.ppn, vpn_q, hit_entry.level);
            pmu_hit_q    <= hit_perm;
            state_q      <= S_IDLE;
          end else begin
            // A or D must be set by the walker, so drop the stale copy and re-walk.
            if (hit) entry_q[hit_idx].valid <= 1'b0;
            pmu_miss_q  <= 1'b1;
            req_valid_q <= 1'b1;
            state_q     <= S_PTW_REQ;
          end
        end
        S_PTW_REQ: begin
          if (ptw_tlb_comm_i.ptw_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_PTW_WAIT;
          end
        end
        S_PTW_WAIT: begin
          if (resp.valid) begin
            resp_valid_q <= 1'b1;
            resp_fault_q <= resp.error || !refill_perm;
            resp_ppn_q   <= form_ppn(resp.pte.ppn, vpn_q, resp.level);
            if (!resp.error && !flush_any)
              entry_q[refill_idx] <= '{valid: 1'b1, vpn: vpn_q, level: resp.level, pte: resp.pte};
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (flush_any)
        for (int i = 0; i < ENTRIES; i++) entry_q[i].valid <= 1'b0;
    end
  end

  assign core_req_ready_o  = (state_q == S_IDLE);
  assign core_resp_valid_o = resp_valid_q;
  assign core_resp_ppn_o   = resp_ppn_q;
  assign core_resp_fault_o = resp_fault_q;
  assign pmu_tlb_hit_o     = pmu_hit_q;
  assign pmu_tlb_miss_o    = pmu_miss_q;
  assign tlb_ptw_comm_o    = '{req: '{valid: req_valid_q, vpn: vpn_q, prv: prv_q,
                                      store: store_q, fetch: fetch_q}};

  assign unused_entry_bits = ^{hit_entry.valid, hit_entry.vpn, hit_entry.pte.rsw,
                               hit_entry.pte.g, hit_entry.pte.v};
endmodule

// File: tb/tb_mmu_tlb.sv
// Directed plus randomized bench for mmu_tlb (Sv39, 4 entries) against a behavioural TLB model.
module tb_mmu_tlb;
  import mmu_pkg::*;
  localparam int N = 4;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                core_req_valid_i, core_req_ready_o;
  logic [VPN_SIZE-1:0] core_req_vpn_i;
  logic [1:0]          core_req_prv_i;
  logic                core_req_store_i, core_req_fetch_i;
  logic                core_resp_valid_o, core_resp_fault_o;
  logic [PPN_SIZE-1:0] core_resp_ppn_o;
  logic                flush_i;
  tlb_ptw_comm_t       tlb_ptw_comm_o;
  ptw_tlb_comm_t       ptw_tlb_comm_i;
  logic                pmu_tlb_hit_o, pmu_tlb_miss_o;

  always #5 clk_i = ~clk_i;

  mmu_tlb #(.ENTRIES(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
    .core_req_vpn_i(core_req_vpn_i), .core_req_prv_i(core_req_prv_i),
    .core_req_store_i(core_req_store_i), .core_req_fetch_i(core_req_fetch_i),
    .core_resp_valid_o(core_resp_valid_o), .core_resp_ppn_o(core_resp_ppn_o),
    .core_resp_fault_o(core_resp_fault_o), .flush_i(flush_i),
    .tlb_ptw_comm_o(tlb_ptw_comm_o), .ptw_tlb_comm_i(ptw_tlb_comm_i),
    .pmu_tlb_hit_o(pmu_tlb_hit_o), .pmu_tlb_miss_o(pmu_tlb_miss_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: entry contents plus last-use time; tree-PLRU victim is
  // the entry reached by always descending into the half whose newest use is older.
  bit                  m_valid[N];
  logic [VPN_SIZE-1:0] m_tag[N];
  int                  m_lvl[N];
  pte_t                m_pte[N];
  int                  m_stamp[N];
  int                  m_time;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void m_clear(input bit also_plru);
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      if (also_plru) m_stamp[i] = 0;
    end
    if (also_plru) m_time = 0;
  endfunction

  function automatic void m_touch(input int i);
    m_time++;
    m_stamp[i] = m_time;
  endfunction

  function automatic int m_lookup(input logic [VPN_SIZE-1:0] vpn);
    int sh;
    for (int i = 0; i < N; i++) begin
      sh = (LEVELS - 1 - m_lvl[i]) * PAGE_LVL_BITS;
      if (m_valid[i] && ((m_tag[i] >> sh) == (vpn >> sh))) return i;
    end
    return -1;
  endfunction

  function automatic int m_newest(input int lo, input int cnt);
    int mx;
    mx = 0;
    for (int i = lo; i < lo + cnt; i++) if (m_stamp[i] > mx) mx = m_stamp[i];
    return mx;
  endfunction

  function automatic int m_victim();
    int lo, size;
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    lo = 0; size = N;
    while (size > 1) begin
      size = size / 2;
      if (m_newest(lo, size) > m_newest(lo + size, size)) lo = lo + size;
    end
    return lo;
  endfunction

  function automatic logic [PPN_SIZE-1:0] m_ppn(input logic [PPN_SIZE-1:0] ppn,
                                                input logic [VPN_SIZE-1:0] vpn, input int lvl);
    logic [PPN_SIZE-1:0] mask;
    mask = (PPN_SIZE'(1) << ((LEVELS - 1 - lvl) * PAGE_LVL_BITS)) - 1;
    return (ppn & ~mask) | (PPN_SIZE'(vpn) & mask);
  endfunction

  function automatic bit m_perm(input pte_t p, input logic [1:0] prv, input bit st, input bit fe);
    bit user_mode, ok;
    user_mode = (prv == 0) || (prv == 1 && ptw_tlb_comm_i.ptw_status.sum);
    ok = fe ? p.x : (st ? (p.w && p.r) : p.r);
    return ok && (p.u == user_mode);
  endfunction

  function automatic pte_t mk_pte(input logic [PPN_SIZE-1:0] ppn, input bit r, input bit w,
                                  input bit x, input bit u, input bit a, input bit d);
    pte_t p;
    p = '0;
    p.ppn = ppn; p.r = r; p.w = w; p.x = x; p.u = u; p.a = a; p.d = d; p.v = 1'b1;
    return p;
  endfunction

  // One full lookup; if the model expects a walk, plays the PTW with random delays.
  task automatic access(input logic [VPN_SIZE-1:0] vpn, input logic [1:0] prv, input bit st,
                        input bit fe, input int w_lvl, input pte_t w_pte, input bit w_err,
                        input bit w_flush);
    int idx, v, d;
    bit exp_walk, exp_fault, exp_hit;
    logic [PPN_SIZE-1:0] exp_ppn;
    exp_walk = 1; exp_hit = 0; exp_fault = 0; exp_ppn = '0;
    idx = m_lookup(vpn);
    if (idx >= 0) begin
      if (!m_perm(m_pte[idx], prv, st, fe)) begin
        exp_walk = 0; exp_fault = 1; m_touch(idx);
      end else if (m_pte[idx].a && (!st || m_pte[idx].d)) begin
        exp_walk = 0; exp_hit = 1; m_touch(idx);
        exp_ppn = m_ppn(m_pte[idx].ppn, vpn, m_lvl[idx]);
      end else m_valid[idx] = 0;
    end
    core_req_valid_i = 1; core_req_vpn_i = vpn; core_req_prv_i = prv;
    core_req_store_i = st; core_req_fetch_i = fe;
    chk("ready_before_accept", core_req_ready_o, 1);
    step();
    core_req_valid_i = 0;
    chk("resp_during_lookup", core_resp_valid_o, 0);
    step();
    chk("pmu_hit", pmu_tlb_hit_o, exp_hit);
    chk("pmu_miss", pmu_tlb_miss_o, exp_walk);
    if (!exp_walk) begin
      chk("hit_resp_valid", core_resp_valid_o, 1);
      chk("hit_resp_fault", core_resp_fault_o, exp_fault);
      if (!exp_fault) chk("hit_resp_ppn", core_resp_ppn_o, exp_ppn);
      chk("hit_no_walk", tlb_ptw_comm_o.req.valid, 0);
    end else begin
      chk("miss_no_early_resp", core_resp_valid_o, 0);
      d = $urandom_range(0, 2);
      for (int k = 0; k <= d; k++) begin
        chk("req_valid_held", tlb_ptw_comm_o.req.valid, 1);
        chk("req_vpn", tlb_ptw_comm_o.req.vpn, vpn);
        chk("req_attr", {tlb_ptw_comm_o.req.prv, tlb_ptw_comm_o.req.store,
                         tlb_ptw_comm_o.req.fetch}, {prv, st, fe});
        if (k < d) step();
      end
      ptw_tlb_comm_i.ptw_ready = 1;
      step();
      ptw_tlb_comm_i.ptw_ready = 0;
      chk("req_dropped_after_hs", tlb_ptw_comm_o.req.valid, 0);
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        step();
        chk("wait_no_resp", core_resp_valid_o, 0);
      end
      ptw_tlb_comm_i.resp.valid = 1; ptw_tlb_comm_i.resp.error = w_err;
      ptw_tlb_comm_i.resp.level = LVL_W'(w_lvl); ptw_tlb_comm_i.resp.pte = w_pte;
      flush_i = w_flush;
      exp_fault = w_err || !m_perm(w_pte, prv, st, fe);
      exp_ppn = m_ppn(w_pte.ppn, vpn, w_lvl);
      step();
      ptw_tlb_comm_i.resp.valid = 0; flush_i = 0;
      chk("walk_resp_valid", core_resp_valid_o, 1);
      chk("walk_resp_fault", core_resp_fault_o, exp_fault);
      if (!exp_fault) chk("walk_resp_ppn", core_resp_ppn_o, exp_ppn);
      if (w_flush) m_clear(0);
      else if (!w_err) begin
        v = m_victim();
        m_valid[v] = 1; m_tag[v] = vpn; m_lvl[v] = w_lvl; m_pte[v] = w_pte;
        m_touch(v);
      end
    end
    step();
    chk("resp_is_pulse", core_resp_valid_o, 0);
    chk("ready_after_resp", core_req_ready_o, 1);
  endtask

  task automatic pulse_flush(input bit via_ptw);
    if (via_ptw) ptw_tlb_comm_i.invalidate_tlb = 1; else flush_i = 1;
    step();
    ptw_tlb_comm_i.invalidate_tlb = 0; flush_i = 0;
    m_clear(0);
  endtask

  task automatic do_reset();
    rst_i = 1;
    step(); step();
    rst_i = 0;
    m_clear(1);
  endtask

  pte_t                p;
  logic [VPN_SIZE-1:0] pool[4];
  logic [VPN_SIZE-1:0] base;
  int                  sel, lvl;
  bit                  st, fe;
  logic [1:0]          prv;

  initial begin
    core_req_valid_i = 0; core_req_vpn_i = '0; core_req_prv_i = 2'd1;
    core_req_store_i = 0; core_req_fetch_i = 0; flush_i = 0;
    ptw_tlb_comm_i = '0;
    do_reset();
    chk("rst_ready", core_req_ready_o, 1);
    chk("rst_resp_valid", core_resp_valid_o, 0);
    chk("rst_pmu", {pmu_tlb_hit_o, pmu_tlb_miss_o}, 0);
    chk("rst_req_valid", tlb_ptw_comm_o.req.valid, 0);

    // Base page refill then hit.
    p = mk_pte(44'h80001, 1, 0, 0, 0, 1, 0);
    access(27'h12345, 2'd1, 0, 0, 2, p, 0, 0);
    access(27'h12345, 2'd1, 0, 0, 2, p, 0, 0);

    // Level-1 superpage: neighbouring vpn translates without a walk.
    pulse_flush(0);
    p = mk_pte(44'h80200, 1, 0, 0, 0, 1, 0);
    access(27'h12345, 2'd1, 0, 0, 1, p, 0, 0);
    access(27'h12355, 2'd1, 0, 0, 1, p, 0, 0);

    // Replacement: fill all, touch 2,1,0, fifth vpn must evict entry 3.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      p = mk_pte(44'h1000 + 44'(i), 1, 0, 0, 0, 1, 0);
      access(27'h00100 + 27'(i) * 27'h10100, 2'd1, 0, 0, 2, p, 0, 0);
      if (i == 3)
        for (int t = 2; t >= 0; t--) access(27'h00100 + 27'(t) * 27'h10100, 2'd1, 0, 0, 2, p, 0, 0);
    end
    for (int t = 0; t < 3; t++) access(27'h00100 + 27'(t) * 27'h10100, 2'd1, 0, 0, 2, p, 0, 0);
    access(27'h00100 + 27'd3 * 27'h10100, 2'd1, 0, 0, 2, p, 0, 0);

    // Store to a clean entry re-walks.
    pulse_flush(1);
    p = mk_pte(44'h2222, 1, 1, 0, 0, 1, 0);
    access(27'h0abcd, 2'd1, 0, 0, 2, p, 0, 0);
    p = mk_pte(44'h2222, 1, 1, 0, 0, 1, 1);
    access(27'h0abcd, 2'd1, 1, 0, 2, p, 0, 0);

    // Privilege: U load to supervisor page faults; S with sum to user page is allowed.
    p = mk_pte(44'h3333, 1, 0, 0, 0, 1, 0);
    access(27'h05555, 2'd1, 0, 0, 2, p, 0, 0);
    access(27'h05555, 2'd0, 0, 0, 2, p, 0, 0);
    p = mk_pte(44'h4444, 1, 0, 0, 1, 1, 0);
    access(27'h06666, 2'd0, 0, 0, 2, p, 0, 0);
    ptw_tlb_comm_i.ptw_status.sum = 1;
    access(27'h06666, 2'd1, 0, 0, 2, p, 0, 0);
    ptw_tlb_comm_i.ptw_status.sum = 0;

    // Flush coinciding with refill: response delivered, nothing stored.
    p = mk_pte(44'h5555, 1, 0, 0, 0, 1, 0);
    access(27'h07777, 2'd1, 0, 0, 2, p, 0, 1);
    access(27'h07777, 2'd1, 0, 0, 2, p, 0, 0);

    // Reset mid-walk; the late walker response must be ignored.
    core_req_valid_i = 1; core_req_vpn_i = 27'h01234; core_req_prv_i = 2'd1;
    core_req_store_i = 0; core_req_fetch_i = 0;
    step();
    core_req_valid_i = 0;
    step();
    chk("rw_req_valid", tlb_ptw_comm_o.req.valid, 1);
    ptw_tlb_comm_i.ptw_ready = 1;
    step();
    ptw_tlb_comm_i.ptw_ready = 0;
    rst_i = 1;
    step();
    rst_i = 0;
    m_clear(1);
    chk("rw_ready_after_rst", core_req_ready_o, 1);
    chk("rw_req_cleared", tlb_ptw_comm_o.req.valid, 0);
    ptw_tlb_comm_i.resp.valid = 1; ptw_tlb_comm_i.resp.error = 0;
    ptw_tlb_comm_i.resp.level = 2'd2; ptw_tlb_comm_i.resp.pte = mk_pte(44'h9999, 1, 0, 0, 0, 1, 0);
    step();
    ptw_tlb_comm_i.resp.valid = 0;
    chk("rw_late_resp_dropped", core_resp_valid_o, 0);
    chk("rw_still_idle", core_req_ready_o, 1);
    access(27'h01234, 2'd1, 0, 0, 2, mk_pte(44'h0aaa, 1, 0, 0, 0, 1, 0), 0, 0);

    // Randomized traffic over a small pool of overlapping vpns.
    pulse_flush(0);
    base = 27'($urandom());
    pool[0] = base; pool[1] = base ^ 27'h00005;
    pool[2] = base ^ 27'h00600; pool[3] = base ^ 27'h4000000;
    for (int it = 0; it < 120; it++) begin
      sel = $urandom_range(0, 3);
      prv = 2'($urandom_range(0, 1));
      st = ($urandom_range(0, 2) == 0);
      fe = !st && ($urandom_range(0, 3) == 0);
      lvl = $urandom_range(0, 2);
      p = mk_pte(44'({$urandom(), $urandom()}), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) pulse_flush($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0)
        ptw_tlb_comm_i.ptw_status.sum = ~ptw_tlb_comm_i.ptw_status.sum;
      access(pool[sel], prv, st, fe, lvl, p, $urandom_range(0, 7) == 0,
             $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
